// File: rtl/mole_tracker.sv
// mole_tracker: per-position mole state, lifetimes and whack detection.
// Optional whiff output enabled by MOLE_TRACKER_WHIFF_EN.
module mole_tracker #(
  parameter int NUM_MOLES  = 18,
  parameter int CLK_PER_MS = 50000,
  parameter int LIFE_L0    = 1500,
  parameter int LIFE_L1    = 1000,
  parameter int LIFE_L2    = 700,
  parameter int LIFE_L3    = 400,
  parameter int MAX_MS     = 2047
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 game_enable,
  input  logic [1:0]           level,
  input  logic                 spawn_valid,
  input  logic [4:0]           spawn_index,
  output logic                 spawn_ready,
  input  logic [NUM_MOLES-1:0] switches,
  output logic [NUM_MOLES-1:0] ledr,
  output logic                 hit,
  output logic [4:0]           hit_count,
  output logic                 miss,
`ifdef MOLE_TRACKER_WHIFF_EN
  output logic                 whiff,
`endif
  output logic [4:0]           active_count
);

  localparam int CW = $clog2(MAX_MS + 1);
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  localparam int L0C = (LIFE_L0 > MAX_MS) ? MAX_MS : LIFE_L0;
  localparam int L1C = (LIFE_L1 > MAX_MS) ? MAX_MS : LIFE_L1;
  localparam int L2C = (LIFE_L2 > MAX_MS) ? MAX_MS : LIFE_L2;
  localparam int L3C = (LIFE_L3 > MAX_MS) ? MAX_MS : LIFE_L3;

  function automatic logic [4:0] popcnt(
    input logic [NUM_MOLES-1:0] v
  );
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < NUM_MOLES; i++)
      c = c + 5'(v[i]);
    return c;
  endfunction

  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick;
  logic [NUM_MOLES-1:0] prev_q;
  logic [NUM_MOLES-1:0] rise;
  logic [NUM_MOLES-1:0] ledr_q, led_d;
  logic [CW-1:0]        cnt_q [NUM_MOLES];
  logic [CW-1:0]        cnt_d [NUM_MOLES];
  logic [NUM_MOLES-1:0] spawn_oh;
  logic [NUM_MOLES-1:0] whack, expire;
  logic                 accept;
  logic [CW-1:0]        life;
  logic                 hit_q, miss_q;
  logic [4:0]           hit_count_q, active_q;

  // free-running ms prescaler; tick on the wrap cycle
  assign tick    = (presc_q == PW'(CLK_PER_MS - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  assign rise = switches & ~prev_q;

  // decode spawn index; out-of-range indices match no slot
  always_comb begin
    spawn_oh = '0;
    for (int i = 0; i < NUM_MOLES; i++)
      spawn_oh[i] = (spawn_index == 5'(i));
  end

  assign spawn_ready = game_enable
                     & (|spawn_oh)
                     & ~(|(spawn_oh & ledr_q));
  assign accept = spawn_valid & spawn_ready;

  // lifetime for the level sampled at spawn
  always_comb begin
    unique case (level)
      2'd0: life = CW'(L0C);
      2'd1: life = CW'(L1C);
      2'd2: life = CW'(L2C);
      default: life = CW'(L3C);
    endcase
  end

  // per-slot next state: disable > spawn > whack > countdown
  always_comb begin
    led_d  = ledr_q;
    whack  = '0;
    expire = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!game_enable) begin
        led_d[i] = 1'b0;
        cnt_d[i] = '0;
      end else if (accept && spawn_oh[i]) begin
        led_d[i] = 1'b1;
        cnt_d[i] = life;
      end else if (ledr_q[i] && rise[i]) begin
        whack[i] = 1'b1;
        led_d[i] = 1'b0;
        cnt_d[i] = '0;
      end else if (ledr_q[i] && tick) begin
        if (cnt_q[i] <= CW'(1)) begin
          expire[i] = 1'b1;
          led_d[i]  = 1'b0;
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end
      end
    end
  end

  // state and registered event outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      prev_q      <= '1;
      ledr_q      <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      hit_count_q <= '0;
      active_q    <= '0;
      for (int i = 0; i < NUM_MOLES; i++)
        cnt_q[i] <= '0;
    end else begin
      presc_q     <= presc_d;
      prev_q      <= switches;
      ledr_q      <= led_d;
      hit_q       <= |whack;
      miss_q      <= |expire;
      hit_count_q <= popcnt(whack);
      active_q    <= popcnt(led_d);
      for (int i = 0; i < NUM_MOLES; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef MOLE_TRACKER_WHIFF_EN
  logic [NUM_MOLES-1:0] whiff_v;
  logic                 whiff_q;

  assign whiff_v = rise & ~ledr_q
                 & ~(spawn_oh & {NUM_MOLES{accept}})
                 & {NUM_MOLES{game_enable}};

  // one pulse for any number of rises on empty slots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) whiff_q <= 1'b0;
    else       whiff_q <= |whiff_v;
  end

  assign whiff = whiff_q;
`endif

  assign ledr         = ledr_q;
  assign hit          = hit_q;
  assign hit_count    = hit_count_q;
  assign miss         = miss_q;
  assign active_count = active_q;

endmodule

// File: tb/tb_mole_tracker.sv
// tb_mole_tracker: directed self-checking bench for mole_tracker.
// Small prescaler and lifetimes keep the run short.
module tb_mole_tracker;

  localparam int N = 18;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         game_enable = 1'b0;
  logic [1:0]   level = 2'd0;
  logic         spawn_valid = 1'b0;
  logic [4:0]   spawn_index = 5'd0;
  logic         spawn_ready;
  logic [N-1:0] switches = '0;
  logic [N-1:0] ledr;
  logic         hit;
  logic [4:0]   hit_count;
  logic         miss;
  logic [4:0]   active_count;
`ifdef MOLE_TRACKER_WHIFF_EN
  logic         whiff;
`endif

  int errs = 0;
  int checks = 0;
  int pc = 0;

  mole_tracker #(
    .NUM_MOLES(N), .CLK_PER_MS(4),
    .LIFE_L0(3), .LIFE_L3(1)
  ) dut (
    .clk(clk), .reset(reset),
    .game_enable(game_enable), .level(level),
    .spawn_valid(spawn_valid),
    .spawn_index(spawn_index),
    .spawn_ready(spawn_ready),
    .switches(switches), .ledr(ledr),
    .hit(hit), .hit_count(hit_count),
    .miss(miss),
`ifdef MOLE_TRACKER_WHIFF_EN
    .whiff(whiff),
`endif
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  // reference ms prescaler: next edge ticks when pc==3
  always @(posedge clk or posedge reset)
    if (reset) pc <= 0;
    else       pc <= (pc == 3) ? 0 : pc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn(input int idx, input int lv);
    spawn_index = 5'(idx);
    level = 2'(lv);
    spawn_valid = 1'b1;
    step();
    spawn_valid = 1'b0;
  endtask

  initial begin
    int clr;
    int mcnt;
    int hseen;
    int tk;
    int done;
    int mseen;

    // reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_ledr", 32'(ledr), 0);
    chk("rst_active", 32'(active_count), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_hitcnt", 32'(hit_count), 0);
    chk("rst_miss", 32'(miss), 0);
    chk("rst_ready", 32'(spawn_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    game_enable = 1'b1;

    // spawn 5 and let it expire
    spawn_index = 5'd5;
    #1;
    chk("t1_ready", 32'(spawn_ready), 1);
    spawn(5, 0);
    chk("t1_ledr", 32'(ledr), 32'h20);
    chk("t1_active", 32'(active_count), 1);
    clr = 0; mcnt = 0; hseen = 0;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (hit) hseen++;
      if (miss) mcnt++;
      if (ledr == '0 && clr == 0) clr = n;
    end
    chk("t1_clr_win",
        32'(clr >= 9 && clr <= 12), 1);
    chk("t1_ledr_end", 32'(ledr), 0);
    chk("t1_miss_cnt", 32'(mcnt), 1);
    chk("t1_no_hit", 32'(hseen), 0);

    // double whack
    spawn(2, 0);
    spawn(9, 0);
    chk("t2_ledr", 32'(ledr), 32'h204);
    chk("t2_active", 32'(active_count), 2);
    switches[2] = 1'b1;
    switches[9] = 1'b1;
    step();
    chk("t2_ledr_clr", 32'(ledr), 0);
    chk("t2_hit", 32'(hit), 1);
    chk("t2_hitcnt", 32'(hit_count), 2);
    chk("t2_miss", 32'(miss), 0);
    chk("t2_active0", 32'(active_count), 0);
    switches = '0;
    step();
    chk("t2_hit_pulse", 32'(hit), 0);

    // level 3: one-tick lifetime
    spawn(6, 3);
    chk("t2b_ledr", 32'(ledr), 32'h40);
    clr = 0; mseen = 0;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (!ledr[6] && clr == 0) begin
        clr = n;
        mseen = int'(miss);
      end
    end
    chk("t2b_clr_win",
        32'(clr >= 1 && clr <= 4), 1);
    chk("t2b_miss", 32'(mseen), 1);

    // whack on the expiry edge
    spawn(4, 0);
    tk = 0; done = 0;
    for (int n = 0; n < 20 && done == 0; n++) begin
      if (pc == 3) tk++;
      if (tk == 3) begin
        switches[4] = 1'b1;
        done = 1;
      end
      step();
    end
    chk("t3_reached", 32'(done), 1);
    chk("t3_hit", 32'(hit), 1);
    chk("t3_hitcnt", 32'(hit_count), 1);
    chk("t3_miss", 32'(miss), 0);
    chk("t3_ledr", 32'(ledr), 0);
    switches = '0;
    step();

    // refused spawns, then disable
    spawn(7, 0);
    chk("t4_ledr", 32'(ledr), 32'h80);
    spawn_index = 5'd7;
    #1;
    chk("t4_busy_rdy", 32'(spawn_ready), 0);
    spawn(7, 0);
    chk("t4_busy_ledr", 32'(ledr), 32'h80);
    spawn_index = 5'd20;
    #1;
    chk("t4_oob_rdy", 32'(spawn_ready), 0);
    spawn(20, 0);
    chk("t4_oob_ledr", 32'(ledr), 32'h80);
    spawn(10, 0);
    spawn(12, 0);
    chk("t4_three", 32'(ledr), 32'h1480);
    chk("t4_active3", 32'(active_count), 3);
    game_enable = 1'b0;
    spawn_index = 5'd13;
    #1;
    chk("t4_dis_rdy", 32'(spawn_ready), 0);
    step();
    chk("t4_dis_ledr", 32'(ledr), 0);
    chk("t4_dis_hit", 32'(hit), 0);
    chk("t4_dis_miss", 32'(miss), 0);
    chk("t4_dis_act", 32'(active_count), 0);
    game_enable = 1'b1;

    // async reset mid countdown, SW0 held
    spawn(1, 0);
    spawn(3, 0);
    switches[0] = 1'b1;
    chk("t6_pre", 32'(ledr), 32'ha);
    #2 reset = 1'b1;
    #1;
    chk("t6_ledr", 32'(ledr), 0);
    chk("t6_active", 32'(active_count), 0);
    chk("t6_hit", 32'(hit), 0);
    chk("t6_miss", 32'(miss), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // pre-held SW0 never counts as a whack
    spawn(0, 0);
    chk("t5_ledr", 32'(ledr), 1);
    step();
    chk("t5_held_hit", 32'(hit), 0);
    chk("t5_held_ledr", 32'(ledr), 1);
    switches[0] = 1'b0;
    step();
    chk("t5_fall_hit", 32'(hit), 0);
    switches[0] = 1'b1;
    step();
    chk("t5_hit", 32'(hit), 1);
    chk("t5_hitcnt", 32'(hit_count), 1);
    chk("t5_ledr0", 32'(ledr), 0);
    switches = '0;
    step();

`ifdef MOLE_TRACKER_WHIFF_EN
    // rise on an empty slot
    switches[11] = 1'b1;
    step();
    chk("t7_whiff", 32'(whiff), 1);
    chk("t7_hit", 32'(hit), 0);
    step();
    chk("t7_whiff_end", 32'(whiff), 0);
    switches = '0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
